// File: rtl/uart_mem_loader.sv
// Boot-stream loader: parses a 16-bit word count plus payload from the UART and writes big-endian words to memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_mem_loader #(
   parameter int WORD_BYTES = 2,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_byte,
   input  logic                    rx_done,
   output logic                    mem_wr,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [8*WORD_BYTES-1:0] mem_wdata,
   output logic                    load_busy,
   output logic                    load_done,
   output logic                    load_err
);

   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, FINISH} state_t;

   state_t                  state_q;
   logic                    rx_q;
   logic                    hold_q;
   logic [7:0]              holdByte_q;
   logic [7:0]              cntHi_q;
   logic [15:0]             wordsLeft_q;
   logic [2:0]              byteIdx_q;
   logic [8*WORD_BYTES-1:0] word_q;

   logic                    byteStb;
   logic                    stb;
   logic                    canTake;
   logic                    lastWr;
   logic [7:0]              stbByte;
   logic [15:0]             lenWord;
   logic [8*WORD_BYTES+7:0] shifted;

   // A strobe that arrives while the FSM cannot consume it is parked in hold_q and replayed next cycle.
   assign byteStb = rx_done & ~rx_q;
   assign stb     = byteStb | hold_q;
   assign stbByte = hold_q ? holdByte_q : rx_byte;
   assign lenWord = {cntHi_q, stbByte};
   assign shifted = {word_q, stbByte};
   assign lastWr  = mem_wr && (wordsLeft_q == 16'd1);
   assign canTake = !((state_q == FINISH) || ((state_q == DATA) && lastWr));

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_q;
`else
   assign load_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rx_q        <= 1'b1;
         hold_q      <= 1'b0;
         holdByte_q  <= 8'h00;
         cntHi_q     <= 8'h00;
         wordsLeft_q <= 16'd0;
         byteIdx_q   <= 3'd0;
         word_q      <= '0;
         mem_wr      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         load_busy   <= 1'b0;
         load_done   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q      <= 8'h00;
         load_err    <= 1'b0;
`endif
      end else begin
         rx_q      <= rx_done;
         load_done <= 1'b0;

         if (mem_wr) begin
            mem_wr      <= 1'b0;
            mem_addr    <= mem_addr + ADDR_WIDTH'(1);
            wordsLeft_q <= wordsLeft_q - 16'd1;
            if (lastWr) begin
`ifdef LOADER_CHECKSUM_EN
               state_q   <= CHECK;
`else
               state_q   <= FINISH;
               load_done <= 1'b1;
               load_busy <= 1'b0;
`endif
            end
         end

         if (stb) begin
            hold_q     <= !canTake;
            holdByte_q <= stbByte;
         end

         case (state_q)
            IDLE, LEN_HI: begin
               if (stb) begin
                  cntHi_q   <= stbByte;
                  load_busy <= 1'b1;
                  state_q   <= LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                  csum_q    <= 8'h00;
                  load_err  <= 1'b0;
`endif
               end
            end
            LEN_LO: begin
               if (stb) begin
                  if (lenWord == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     state_q   <= CHECK;
`else
                     state_q   <= FINISH;
                     load_done <= 1'b1;
                     load_busy <= 1'b0;
`endif
                  end else begin
                     wordsLeft_q <= lenWord;
                     mem_addr    <= '0;
                     byteIdx_q   <= 3'd0;
                     state_q     <= DATA;
                  end
               end
            end
            DATA: begin
               if (stb && !lastWr) begin
`ifdef LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ stbByte;
`endif
                  word_q <= shifted[8*WORD_BYTES-1:0];
                  if (byteIdx_q == 3'(WORD_BYTES - 1)) begin
                     byteIdx_q <= 3'd0;
                     mem_wr    <= 1'b1;
                     mem_wdata <= shifted[8*WORD_BYTES-1:0];
                  end else begin
                     byteIdx_q <= byteIdx_q + 3'd1;
                  end
               end
            end
            CHECK: begin
`ifdef LOADER_CHECKSUM_EN
               if (stb) begin
                  load_err  <= (stbByte != csum_q);
                  load_done <= 1'b1;
                  load_busy <= 1'b0;
                  state_q   <= FINISH;
               end
`else
               state_q <= FINISH;
`endif
            end
            FINISH: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Downstream consumer of the UART receiver. Takes each received byte (rx_byte qualified by the rx_done level) and parses a length-prefixed boot stream. Assembles payload bytes into memory words and issues single-cycle write strobes into processor instruction/data memory. Holds the CPU off (load_busy) while a load is in progress.

Parameters:
WORD_BYTES, 2, bytes per memory word; first received byte of a word is the MSB (big-endian); range 1..4
ADDR_WIDTH, 8, memory address width; write address wraps modulo 2^ADDR_WIDTH

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx_byte  input  8  received byte from the UART receiver, stable while rx_done is high
rx_done  input  1  receiver done level; rises once per byte, stays high until the next start bit
mem_wr  output  1  one-cycle memory write strobe
mem_addr  output  ADDR_WIDTH  write address, valid when mem_wr=1
mem_wdata  output  8*WORD_BYTES  write data, valid when mem_wr=1
load_busy  output  1  load in progress; the CPU stalls while this is high
load_done  output  1  one-cycle pulse at end of load
load_err  output  1  checksum mismatch flag (see Optional Feature)

Behaviour:
- Clocking/reset: one clock, clk; rst is synchronous and active-high.
- Reset values: mem_wr=0, mem_addr=0, mem_wdata=0, load_busy=0, load_done=0, load_err=0, state=IDLE, word count=0, byte index=0.
- Byte strobe: rx_done is registered into rx_q. byte_stb = rx_done & ~rx_q.
  - rx_q resets to 1, so a stale-high rx_done after reset is never counted.
  - rx_byte is sampled on the edge where byte_stb=1.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, FINISH.
  - IDLE: on byte_stb, latch the byte as count[15:8], set load_busy=1, go to LEN_LO. (LEN_HI is the entry alias of this step and is encoded but never idles.)
  - LEN_LO: on byte_stb, latch count[7:0].
    - If count==0: go to CHECK when the checksum feature is compiled in, else to FINISH.
    - Otherwise go to DATA with addr=0 and byte_idx=0.
  - DATA: on each byte_stb, shift the byte into the word register (MSB first) and increment byte_idx.
    - When byte_idx reaches WORD_BYTES: mem_wr=1 in the next cycle for exactly one cycle, with mem_addr=current address and mem_wdata=the assembled word. Then the address increments, wrapping at 2^ADDR_WIDTH, and words_left decrements.
    - After the write of the last word: go to CHECK when the feature is compiled in, else to FINISH.
  - FINISH: one cycle. load_done=1, load_busy=0 in this same cycle, then go to IDLE.
- Latency: last byte of a word sampled at edge t -> mem_wr high during cycle t+1. The final write is followed by FINISH in cycle t+2.
- Byte stream rates: bytes are at least 10 bit-times apart, so a write never coincides with a new byte_stb. The design must still never drop a byte_stb that lands during a mem_wr cycle.
- Word count: 16 bits, 0..65535 words. A count larger than 2^ADDR_WIDTH wraps the address and overwrites earlier words. This is defined behaviour.
- Reset mid-load: the partial word is discarded, the address returns to 0, and there is no load_done. The next byte_stb is treated as a new count high byte.
- mem_wdata holds its last value between writes; mem_addr shows the next write address.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR is kept over all payload bytes; header bytes are excluded. It is cleared on entry to LEN_LO.
  - In CHECK, the next byte_stb compares the received byte against the XOR. The result sets load_err (1 on mismatch), then the FSM goes to FINISH.
  - load_err holds until the next load starts (byte_stb in IDLE) or rst.
  - For count==0, the expected checksum is 0x00.
- Undefined: the CHECK state and XOR logic are absent, load_err is tied to 0, and FINISH follows the last write directly.

Test Plan:
1. rst with rx_done held high for 20 cycles, then released -> no byte captured, load_busy=0, mem_wr never asserted.
2. WORD_BYTES=2, bytes 00 02 12 34 AB CD -> writes (addr 0, 0x1234), then (addr 1, 0xABCD). load_done pulses 1 cycle after the second mem_wr; load_busy falls in that same cycle.
3. Bytes 00 00 (feature off) -> load_done pulse after the second byte, zero mem_wr pulses.
4. Bytes 00 03 11, rst asserted for one cycle, then 00 01 55 66 -> exactly one write (addr 0, 0x5566), one load_done.
5. LOADER_CHECKSUM_EN defined:
   - Bytes 00 01 12 34 26 -> write 0x1234, load_done, load_err=0.
   - Bytes 00 01 12 34 27 -> load_done, load_err=1, held until the next count byte.
6. ADDR_WIDTH=2, WORD_BYTES=1, count 5, payload 01..05 -> writes to addresses 0,1,2,3,0 with data 01,02,03,04,05.
